// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: widths, decoded memory-reference opcode, execute-stage
// state/opcode enums and small routing helpers.
package pdp8_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;

    localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200;
    localparam logic [ADDR_WIDTH-1:0] AUTO_INDEX_LO = 12'o0010;
    localparam logic [ADDR_WIDTH-1:0] AUTO_INDEX_HI = 12'o0017;

    typedef struct packed {
        logic       AND;
        logic       TAD;
        logic       ISZ;
        logic       DCA;
        logic       JMS;
        logic       JMP;
        logic [8:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef enum logic [2:0] {
        IDLE,
        IND_REQ,
        IND_WAIT,
        AUTO_WR,
        OP_REQ,
        OP_WAIT,
        WRITE,
        DONE
    } exec_memref_state_e;

    typedef enum logic [2:0] {
        OP_AND,
        OP_TAD,
        OP_ISZ,
        OP_DCA,
        OP_JMS,
        OP_JMP
    } mem_op_e;

    // Priority AND > TAD > ISZ > DCA > JMS > JMP when several flags arrive together.
    function automatic mem_op_e pick_op(input pdp_mem_opcode_s op);
        if (op.AND)      return OP_AND;
        else if (op.TAD) return OP_TAD;
        else if (op.ISZ) return OP_ISZ;
        else if (op.DCA) return OP_DCA;
        else if (op.JMS) return OP_JMS;
        else             return OP_JMP;
    endfunction

    function automatic logic [5:0] op_flags(input pdp_mem_opcode_s op);
        return {op.AND, op.TAD, op.ISZ, op.DCA, op.JMS, op.JMP};
    endfunction

    function automatic logic multi_flag(input pdp_mem_opcode_s op);
        logic [5:0] f;
        f = op_flags(op);
        return (f & (f - 6'd1)) != 6'd0;
    endfunction

    // First state after the effective address is final (no more indirection).
    function automatic exec_memref_state_e route_state(input mem_op_e op);
        case (op)
            OP_AND, OP_TAD, OP_ISZ: return OP_REQ;
            OP_DCA, OP_JMS:         return WRITE;
            default:                return DONE;
        endcase
    endfunction

endpackage

// File: rtl/exec_memref_unit_if.sv
// Memory port of the memory-reference execute stage: one-cycle read strobe with
// data back MEM_LAT cycles later, and a fire-and-forget write strobe.
interface exec_memref_unit_if;
    import pdp8_pkg::*;

    logic                  exec_rd_req;
    logic [ADDR_WIDTH-1:0] exec_rd_addr;
    logic [DATA_WIDTH-1:0] exec_rd_data;
    logic                  exec_wr_req;
    logic [ADDR_WIDTH-1:0] exec_wr_addr;
    logic [DATA_WIDTH-1:0] exec_wr_data;

    modport master (
        output exec_rd_req,
        output exec_rd_addr,
        input  exec_rd_data,
        output exec_wr_req,
        output exec_wr_addr,
        output exec_wr_data
    );

    modport slave (
        input  exec_rd_req,
        input  exec_rd_addr,
        output exec_rd_data,
        input  exec_wr_req,
        input  exec_wr_addr,
        input  exec_wr_data
    );

endinterface

// File: rtl/exec_memref_unit_ea_calc.sv
// Effective-address former: page-zero or current-page addressing from {I, P, offset},
// plus a flag telling whether the address lies in the auto-index window.
module ea_calc
    import pdp8_pkg::*;
(
    input  logic [8:0]            mem_inst_addr,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] ea,
    output logic                  is_auto_index
);

    logic [ADDR_WIDTH-1:0] page_base;
    logic [ADDR_WIDTH-1:0] offset_addr;

    assign page_base   = base_addr & 12'o7600;
    assign offset_addr = {5'b0, mem_inst_addr[6:0]};

    always_comb begin
        ea            = mem_inst_addr[7] ? (page_base | offset_addr) : offset_addr;
        is_auto_index = (ea >= AUTO_INDEX_LO) && (ea <= AUTO_INDEX_HI);
    end

endmodule

// File: rtl/exec_memref_unit.sv
// Memory-reference execute stage (AND/TAD/ISZ/DCA/JMS/JMP) owning AC, Link and PC.
// Define PDP8_AUTO_INDEX_EN to enable pre-increment through locations 0010-0017.
module exec_memref_unit
    import pdp8_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dec_valid,
    input  pdp_mem_opcode_s          pdp_mem_opcode,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    output logic                     stall,
    output logic [ADDR_WIDTH-1:0]    PC_value,
    exec_memref_unit_if.master       mem,
    output logic [DATA_WIDTH-1:0]    acc,
    output logic                     link,
    output logic                     err_multi
);

    generate
        if (MEM_LAT != 1) begin : g_mem_lat_check
            $error("exec_memref_unit: only MEM_LAT = 1 is supported");
        end
    endgenerate

`ifdef PDP8_AUTO_INDEX_EN
    localparam bit AUTO_INDEX_EN = 1'b1;
`else
    localparam bit AUTO_INDEX_EN = 1'b0;
`endif

    exec_memref_state_e state;
    exec_memref_state_e next_state;

    mem_op_e               op_q;
    logic [ADDR_WIDTH-1:0] ea_q;
    logic [ADDR_WIDTH-1:0] ind_addr_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] tmp_q;
    logic                  auto_q;

    logic [ADDR_WIDTH-1:0] ea_in;
    logic                  auto_in;
    logic                  accept;
    logic [DATA_WIDTH:0]   tad_sum;

    ea_calc u_ea_calc (
        .mem_inst_addr (pdp_mem_opcode.mem_inst_addr),
        .base_addr     (base_addr),
        .ea            (ea_in),
        .is_auto_index (auto_in)
    );

    assign accept  = (state == IDLE) && dec_valid && (op_flags(pdp_mem_opcode) != 6'd0);
    assign tad_sum = {1'b0, acc} + {1'b0, mem.exec_rd_data};
    assign stall   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are decoded from the registered state so a read and a write can never coincide.
    always_comb begin
        next_state        = state;
        mem.exec_rd_req   = 1'b0;
        mem.exec_rd_addr  = ea_q;
        mem.exec_wr_req   = 1'b0;
        mem.exec_wr_addr  = ea_q;
        mem.exec_wr_data  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = pdp_mem_opcode.mem_inst_addr[8] ? IND_REQ
                                                                 : route_state(pick_op(pdp_mem_opcode));
                end
            end
            IND_REQ: begin
                mem.exec_rd_req = 1'b1;
                next_state      = IND_WAIT;
            end
            IND_WAIT: begin
                next_state = (AUTO_INDEX_EN && auto_q) ? AUTO_WR : route_state(op_q);
            end
            AUTO_WR: begin
                mem.exec_wr_req  = 1'b1;
                mem.exec_wr_addr = ind_addr_q;
                mem.exec_wr_data = ea_q;
                next_state       = route_state(op_q);
            end
            OP_REQ: begin
                mem.exec_rd_req = 1'b1;
                next_state      = OP_WAIT;
            end
            OP_WAIT: begin
                next_state = (op_q == OP_ISZ) ? WRITE : DONE;
            end
            WRITE: begin
                mem.exec_wr_req = 1'b1;
                case (op_q)
                    OP_DCA:  mem.exec_wr_data = acc;
                    OP_ISZ:  mem.exec_wr_data = tmp_q;
                    OP_JMS:  mem.exec_wr_data = base_q + ADDR_WIDTH'(1);
                    default: mem.exec_wr_data = '0;
                endcase
                next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Architectural registers and per-instruction context; a reset mid-read simply drops the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            link       <= 1'b0;
            err_multi  <= 1'b0;
            PC_value   <= START_ADDRESS;
            op_q       <= OP_JMP;
            ea_q       <= '0;
            ind_addr_q <= '0;
            base_q     <= '0;
            tmp_q      <= '0;
            auto_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= pick_op(pdp_mem_opcode);
                        ea_q       <= ea_in;
                        ind_addr_q <= ea_in;
                        auto_q     <= auto_in;
                        base_q     <= base_addr;
                        if (multi_flag(pdp_mem_opcode)) begin
                            err_multi <= 1'b1;
                        end
                    end
                end
                IND_WAIT: begin
                    if (AUTO_INDEX_EN && auto_q) begin
                        ea_q <= mem.exec_rd_data + DATA_WIDTH'(1);
                    end else begin
                        ea_q <= mem.exec_rd_data;
                    end
                end
                OP_WAIT: begin
                    case (op_q)
                        OP_AND: acc <= acc & mem.exec_rd_data;
                        OP_TAD: begin
                            acc  <= tad_sum[DATA_WIDTH-1:0];
                            link <= link ^ tad_sum[DATA_WIDTH];
                        end
                        OP_ISZ: tmp_q <= mem.exec_rd_data + DATA_WIDTH'(1);
                        default: ;
                    endcase
                end
                WRITE: begin
                    if (op_q == OP_DCA) begin
                        acc <= '0;
                    end
                end
                DONE: begin
                    case (op_q)
                        OP_JMP:  PC_value <= ea_q;
                        OP_JMS:  PC_value <= ea_q + ADDR_WIDTH'(1);
                        OP_ISZ:  PC_value <= (tmp_q == '0) ? base_q + ADDR_WIDTH'(2)
                                                           : base_q + ADDR_WIDTH'(1);
                        default: PC_value <= base_q + ADDR_WIDTH'(1);
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_memref_unit.sv
// Scoreboard bench for exec_memref_unit: directed instructions push expected reads,
// writes and completion state; a negedge monitor pops and compares them.
module tb_exec_memref_unit;
    import pdp8_pkg::*;

    typedef struct { int addr; int data; } wr_exp_t;
    typedef struct { int pc; int acc; int link; int err; int cycles; } done_exp_t;
    typedef struct { int stall; int rd; int wr; int acc; int pc; int link; int err; } snap_exp_t;

    logic                  clk;
    logic                  reset;
    logic                  decValid;
    pdp_mem_opcode_s       decOp;
    logic [ADDR_WIDTH-1:0] baseAddr;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] pcValue;
    logic [DATA_WIDTH-1:0] acc;
    logic                  link;
    logic                  errMulti;

    exec_memref_unit_if memIf();

    logic [DATA_WIDTH-1:0] mem [0:4095];
    logic                  pokeEn;
    logic [11:0]           pokeAddr;
    logic [11:0]           pokeData;
    logic                  stimDone;

    int        rdQ[$];
    wr_exp_t   wrQ[$];
    done_exp_t doneQ[$];
    snap_exp_t snapQ[$];

    int   passCount  = 0;
    int   checkCount = 0;
    int   stallCnt   = 0;
    logic prevStall  = 1'b0;

    exec_memref_unit dut (
        .clk            (clk),
        .reset          (reset),
        .dec_valid      (decValid),
        .pdp_mem_opcode (decOp),
        .base_addr      (baseAddr),
        .stall          (stall),
        .PC_value       (pcValue),
        .mem            (memIf),
        .acc            (acc),
        .link           (link),
        .err_multi      (errMulti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle-latency memory; pokes preload it while the DUT is idle.
    always @(posedge clk) begin
        if (memIf.exec_rd_req) memIf.exec_rd_data <= mem[memIf.exec_rd_addr];
        if (pokeEn) mem[pokeAddr] <= pokeData;
        else if (memIf.exec_wr_req) mem[memIf.exec_wr_addr] <= memIf.exec_wr_data;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0o, expected %0o", name, actual, expected);
    endtask

    // Monitor: compares every strobe and every completion against the queued expectations.
    always @(negedge clk) begin
        snap_exp_t s;
        wr_exp_t   w;
        done_exp_t d;
        int        a;
        if (snapQ.size() > 0) begin
            s = snapQ.pop_front();
            checkOutput("snap_stall", int'(stall), s.stall);
            checkOutput("snap_rd_req", int'(memIf.exec_rd_req), s.rd);
            checkOutput("snap_wr_req", int'(memIf.exec_wr_req), s.wr);
            checkOutput("snap_acc", int'(acc), s.acc);
            checkOutput("snap_pc", int'(pcValue), s.pc);
            checkOutput("snap_link", int'(link), s.link);
            checkOutput("snap_err_multi", int'(errMulti), s.err);
        end
        if (memIf.exec_rd_req || memIf.exec_wr_req)
            checkOutput("rd_wr_exclusive", int'(memIf.exec_rd_req && memIf.exec_wr_req), 0);
        if (memIf.exec_rd_req) begin
            if (rdQ.size() == 0) checkOutput("unexpected_read", int'(memIf.exec_rd_addr), -1);
            else begin
                a = rdQ.pop_front();
                checkOutput("rd_addr", int'(memIf.exec_rd_addr), a);
            end
        end
        if (memIf.exec_wr_req) begin
            if (wrQ.size() == 0) checkOutput("unexpected_write", int'(memIf.exec_wr_addr), -1);
            else begin
                w = wrQ.pop_front();
                checkOutput("wr_addr", int'(memIf.exec_wr_addr), w.addr);
                checkOutput("wr_data", int'(memIf.exec_wr_data), w.data);
            end
        end
        if (reset) begin
            stallCnt  = 0;
            prevStall = 1'b0;
        end else begin
            if (stall) begin
                stallCnt++;
                if (stallCnt == 41) checkOutput("stall_timeout", stallCnt, 40);
            end else if (prevStall) begin
                if (doneQ.size() == 0) checkOutput("unexpected_done", int'(pcValue), -1);
                else begin
                    d = doneQ.pop_front();
                    checkOutput("done_pc", int'(pcValue), d.pc);
                    checkOutput("done_acc", int'(acc), d.acc);
                    checkOutput("done_link", int'(link), d.link);
                    checkOutput("done_err_multi", int'(errMulti), d.err);
                    checkOutput("done_stall_cycles", stallCnt, d.cycles);
                end
                stallCnt = 0;
            end
            prevStall = stall;
        end
        if (stimDone) begin
            checkOutput("rd_queue_empty", rdQ.size(), 0);
            checkOutput("wr_queue_empty", wrQ.size(), 0);
            checkOutput("done_queue_empty", doneQ.size(), 0);
            $display("%0d/%0d checks passed", passCount, checkCount);
            $finish;
        end
    end

    function automatic pdp_mem_opcode_s decodeInstr(input logic [11:0] instr);
        pdp_mem_opcode_s o;
        o = '0;
        case (instr[11:9])
            3'd0: o.AND = 1'b1;
            3'd1: o.TAD = 1'b1;
            3'd2: o.ISZ = 1'b1;
            3'd3: o.DCA = 1'b1;
            3'd4: o.JMS = 1'b1;
            3'd5: o.JMP = 1'b1;
            default: ;
        endcase
        o.mem_inst_addr = instr[8:0];
        return o;
    endfunction

    task automatic expectRead(input int addr);
        rdQ.push_back(addr);
    endtask

    task automatic expectWrite(input int addr, input int data);
        wr_exp_t w;
        w.addr = addr;
        w.data = data;
        wrQ.push_back(w);
    endtask

    task automatic expectDone(input int pc, input int accV, input int linkV, input int err, input int cycles);
        done_exp_t d;
        d.pc = pc; d.acc = accV; d.link = linkV; d.err = err; d.cycles = cycles;
        doneQ.push_back(d);
    endtask

    task automatic expectSnap(input int st, input int rd, input int wr, input int accV,
                              input int pc, input int linkV, input int err);
        snap_exp_t s;
        s.stall = st; s.rd = rd; s.wr = wr; s.acc = accV; s.pc = pc; s.link = linkV; s.err = err;
        snapQ.push_back(s);
    endtask

    task automatic pokeMem(input logic [11:0] addr, input logic [11:0] data);
        @(posedge clk); #1;
        pokeEn = 1'b1; pokeAddr = addr; pokeData = data;
        @(posedge clk); #1;
        pokeEn = 1'b0;
    endtask

    task automatic pulseDec(input pdp_mem_opcode_s op, input logic [11:0] base);
        @(posedge clk); #1;
        decValid = 1'b1; decOp = op; baseAddr = base;
        @(posedge clk); #1;
        decValid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 60; i++) begin
            if (!stall) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus(input logic [11:0] instr, input logic [11:0] base);
        pulseDec(decodeInstr(instr), base);
        waitIdle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        pdp_mem_opcode_s op;
        reset = 1'b1; decValid = 1'b0; decOp = '0; baseAddr = '0;
        pokeEn = 1'b0; pokeAddr = '0; pokeData = '0; stimDone = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expectSnap(0, 0, 0, 0, 'o0200, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        pokeMem(12'o0005, 12'o7777);
        pokeMem(12'o0006, 12'o7070);
        pokeMem(12'o0205, 12'o0707);
        pokeMem(12'o0020, 12'o7777);
        pokeMem(12'o0021, 12'o0005);
        pokeMem(12'o0010, 12'o3000);
        pokeMem(12'o0040, 12'o0006);

        $display("[TB] direct TAD pair with carry into link");
        expectRead('o0005); expectDone('o0201, 'o7777, 0, 0, 3);
        applyStimulus(12'o1005, 12'o0200);
        pokeMem(12'o0005, 12'o0001);
        expectRead('o0005); expectDone('o0202, 'o0000, 1, 0, 3);
        applyStimulus(12'o1005, 12'o0201);

        $display("[TB] load AC then current-page AND");
        expectRead('o0006); expectDone('o0203, 'o7070, 1, 0, 3);
        applyStimulus(12'o1006, 12'o0202);
        expectRead('o0205); expectDone('o0201, 'o0000, 1, 0, 3);
        applyStimulus(12'o0205, 12'o0200);

        $display("[TB] ISZ with and without skip");
        expectRead('o0020); expectWrite('o0020, 'o0000); expectDone('o0302, 0, 1, 0, 4);
        applyStimulus(12'o2020, 12'o0300);
        expectRead('o0021); expectWrite('o0021, 'o0006); expectDone('o0301, 0, 1, 0, 4);
        applyStimulus(12'o2021, 12'o0300);

        $display("[TB] JMS and DCA");
        expectWrite('o0250, 'o0201); expectDone('o0251, 0, 1, 0, 2);
        applyStimulus(12'o4250, 12'o0200);
        expectRead('o0006); expectDone('o0401, 'o7070, 1, 0, 3);
        applyStimulus(12'o1006, 12'o0400);
        expectWrite('o0030, 'o7070); expectDone('o0401, 0, 1, 0, 2);
        applyStimulus(12'o3030, 12'o0400);

        $display("[TB] indirect JMP through location 0010");
        expectRead('o0010);
`ifdef PDP8_AUTO_INDEX_EN
        expectWrite('o0010, 'o3001); expectDone('o3001, 0, 1, 0, 4);
`else
        expectDone('o3000, 0, 1, 0, 3);
`endif
        applyStimulus(12'o5410, 12'o0500);

        $display("[TB] plain indirect TAD, top-of-memory JMP, ISZ PC wrap");
        expectRead('o0040); expectRead('o0006); expectDone('o0601, 'o7070, 1, 0, 5);
        applyStimulus(12'o1440, 12'o0600);
        expectDone('o7777, 'o7070, 1, 0, 1);
        applyStimulus(12'o5377, 12'o7600);
        expectRead('o0020); expectWrite('o0020, 'o0001); expectDone('o0000, 'o7070, 1, 0, 4);
        applyStimulus(12'o2020, 12'o7777);

        $display("[TB] multiple flags: AND wins over JMP");
        op = '0; op.AND = 1'b1; op.JMP = 1'b1; op.mem_inst_addr = 9'o005;
        expectRead('o0005); expectDone('o0701, 0, 1, 1, 3);
        pulseDec(op, 12'o0700);
        waitIdle();

        $display("[TB] zero flags ignored");
        op = '0; op.mem_inst_addr = 9'o005;
        pulseDec(op, 12'o0100);
        expectSnap(0, 0, 0, 0, 'o0701, 1, 1);

        $display("[TB] dec_valid while busy ignored");
        expectRead('o0006); expectDone('o1001, 'o7070, 1, 1, 3);
        pulseDec(decodeInstr(12'o1006), 12'o1000);
        decValid = 1'b1; decOp = decodeInstr(12'o5100); baseAddr = 12'o2000;
        @(posedge clk); #1;
        decValid = 1'b0;
        waitIdle();

        $display("[TB] reset during OP_WAIT of a TAD");
        expectRead('o0005);
        pulseDec(decodeInstr(12'o1005), 12'o0200);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        expectSnap(0, 0, 0, 0, 'o0200, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        expectRead('o0005); expectDone('o0201, 'o0001, 0, 0, 3);
        applyStimulus(12'o1005, 12'o0200);

        repeat (2) @(posedge clk);
        #1;
        stimDone = 1'b1;
    end

endmodule
